// File: rtl/data_mem_if.sv
// Data-memory request/response bus between the core MEM stage (master) and the RAM responder (slave).
interface data_mem_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        err_o;

    modport master (
        output ce_i, we_i, addr_i, wdata_i,
        input  rdata_o, ready_o, err_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, wdata_i,
        output rdata_o, ready_o, err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering core data-memory requests, with programmable wait states,
// a one-cycle ready pulse and an error flag for misaligned or out-of-range addresses.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);
    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        req_we_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic        cur_err;
    logic        resp_err;
    logic        accept;
    logic        enter_resp;

    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    assign accept = (state_q == S_IDLE) && bus.ce_i;

    // With no wait states the commit edge is also the latch edge, so the live bus is used.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = bus.we_i;
            cur_addr  = bus.addr_i;
            cur_wdata = bus.wdata_i;
        end else begin
            cur_we    = req_we_q;
            cur_addr  = req_addr_q;
            cur_wdata = req_wdata_q;
        end
    end

    assign cur_idx = cur_addr[IDX_W+1:2];
    assign cur_err = (cur_addr[1:0] != 2'b00) ||
                     ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign resp_err = (req_addr_q[1:0] != 2'b00) ||
                      ({2'b00, req_addr_q[31:2]} >= 32'(DEPTH_WORDS));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ce_i) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'd0;
            req_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_we_q    <= bus.we_i;
                req_addr_q  <= bus.addr_i;
                req_wdata_q <= bus.wdata_i;
            end
            if (enter_resp && !cur_we) begin
                rdata_q <= cur_err ? 32'd0 : mem[cur_idx];
            end else if (enter_resp && cur_err) begin
                rdata_q <= 32'd0;
            end
        end
    end

    // NOTE: the RAM array has no reset; the rst_n gate makes a reset on the commit edge win.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && cur_we && !cur_err) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign bus.rdata_o = rdata_q;
    assign bus.ready_o = (state_q == S_RESP);
    assign bus.err_o   = (state_q == S_RESP) && resp_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (0, 3 and 2 wait states) driven from a vector table
// and hand-written sequences, with responses checked against a per-unit scoreboard.
module tb_data_mem_responder;
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int          unit;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    logic        clk;
    logic [2:0]  rst_n;
    logic [2:0]  ce;
    logic [2:0]  we;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  rdy;
    logic [2:0]  err;

    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb [3][$];

    for (genvar g = 0; g < 3; g++) begin : unit
        data_mem_if bus ();
        assign bus.ce_i    = ce[g];
        assign bus.we_i    = we[g];
        assign bus.addr_i  = addr[g];
        assign bus.wdata_i = wdata[g];
        assign rdata[g]    = bus.rdata_o;
        assign rdy[g]      = bus.ready_o;
        assign err[g]      = bus.err_o;

        data_mem_responder #(
            .DEPTH_WORDS (1024),
            .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n[g]),
            .bus   (bus.slave)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ws_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 3 : 2);
    endfunction

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d: got %h required %h", name, u, act, exp);
        end
    endtask

    // Response monitor: every ready pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 3; u++) begin
            if (rst_n[u] === 1'b1) begin
                if (rdy[u] === 1'b1) begin
                    if (sb[u].size() == 0) begin
                        check("unexpected_ready", u, 32'd1, 32'd0);
                    end else begin
                        e = sb[u].pop_front();
                        check("ready_cycle", u, 32'(cyc), 32'(e.cyc));
                        check("err", u, {31'd0, err[u]}, {31'd0, e.err});
                        check("rdata", u, rdata[u], e.rd);
                    end
                end else begin
                    check("err_without_ready", u, {31'd0, err[u]}, 32'd0);
                end
            end
        end
    end

    task automatic do_req(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input bit exp_e, output int rc);
        exp_t e;
        ce[u]    = 1'b1;
        we[u]    = w;
        addr[u]  = a;
        wdata[u] = d;
        e.rd  = exp_rd;
        e.err = exp_e;
        e.cyc = cyc + 1 + ws_of(u);
        sb[u].push_back(e);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[u] === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            check("ready_timeout", u, 32'd0, 32'd1);
            void'(sb[u].pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int u);
        ce[u] = 1'b0;
        we[u] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input int u);
        check("rst_rdata", u, rdata[u], 32'd0);
        check("rst_ready", u, {31'd0, rdy[u]}, 32'd0);
        check("rst_err", u, {31'd0, err[u]}, 32'd0);
    endtask

    vec_t        vecs [14];
    logic [31:0] seed [2];
    logic [31:0] last_rd, last_wr;
    int          rc, prev, k;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 3'b000;
        ce       = 3'b000;
        we       = 3'b000;
        for (int u = 0; u < 3; u++) begin
            addr[u]  = 32'd0;
            wdata[u] = 32'd0;
        end

        vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vecs[3]  = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{0, 1'b1, 32'h0000_1000, 32'h0102_0304, 32'h0000_0000, 1'b1};
        vecs[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b0};
        vecs[8]  = '{0, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[9]  = '{0, 1'b0, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{0, 1'b0, 32'h0000_1002, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[11] = '{0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[12] = '{1, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[13] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check_zero_outputs(u);
        rst_n = 3'b111;
        @(posedge clk);
        #1;

        // Vector table: aligned, misaligned, top word and out-of-range accesses.
        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].unit, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_err, rc);
            idle(vecs[i].unit);
        end

        // Three wait states: ce toggling and a stray write during WAIT must be ignored.
        k = cyc;
        ce[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; wdata[1] = 32'h0;
        sb[1].push_back('{32'h1234_5678, 1'b0, k + 4});
        @(posedge clk); #1;
        ce[1] = 1'b0;
        @(posedge clk); #1;
        ce[1] = 1'b1; we[1] = 1'b1; wdata[1] = 32'hFFFF_0000;
        @(posedge clk); #1;
        ce[1] = 1'b0; we[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("toggle_resp_popped", 1, 32'(sb[1].size()), 32'd0);
        do_req(1, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 1'b0, rc);
        idle(1);

        // Two wait states: reset during WAIT aborts the write and clears outputs at once.
        do_req(2, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, rc);
        idle(2);
        do_req(2, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, rc);
        idle(2);
        ce[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        ce[2] = 1'b0; we[2] = 1'b0;
        rst_n[2] = 1'b0;
        #1;
        check_zero_outputs(2);
        repeat (3) @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_req(2, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, rc);
        idle(2);

        // ce held high: back-to-back write/read pairs at the minimum issue interval.
        seed[0] = 32'hDEAD_BEEF;
        seed[1] = 32'h1234_5678;
        for (int u = 0; u < 2; u++) begin
            last_rd = seed[u];
            last_wr = 32'h0;
            prev    = -1;
            for (int i = 0; i < 6; i++) begin
                if (i % 2 == 0) begin
                    last_wr = 32'h4000_0000 | 32'(i);
                    do_req(u, 1'b1, 32'h40, last_wr, last_rd, 1'b0, rc);
                end else begin
                    last_rd = last_wr;
                    do_req(u, 1'b0, 32'h40, 32'h0, last_rd, 1'b0, rc);
                end
                if (prev >= 0) check("issue_interval", u, 32'(rc - prev), 32'(ws_of(u) + 2));
                prev = rc;
            end
            idle(u);
        end

        repeat (6) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) check("scoreboard_drained", u, 32'(sb[u].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
